// File: rtl/mc_pkg.sv
// rtl/mc_pkg.sv - shared states, opcodes and select encodings for the multi-cycle controller
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXEC      = 4'd6,
    S_ALU_WB    = 4'd7,
    S_BRANCH    = 4'd8,
    S_JAL       = 4'd9,
    S_HALT      = 4'd10
  } state_t;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_SD  = 7'b0100011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SLL = 4'b0011;
  localparam logic [3:0] ALU_SRL = 4'b0100;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_BRT = 4'b1000;
  localparam logic [3:0] ALU_B2A = 4'b1001;

  localparam logic       SRC_A_PC   = 1'b0;
  localparam logic       SRC_A_REG  = 1'b1;
  localparam logic [1:0] SRC_B_REG  = 2'b00;
  localparam logic [1:0] SRC_B_FOUR = 2'b01;
  localparam logic [1:0] SRC_B_IMM  = 2'b10;

  localparam logic [1:0] M2R_ALUOUT = 2'b00;
  localparam logic [1:0] M2R_MDR    = 2'b01;
  localparam logic [1:0] M2R_PC     = 2'b10;

  localparam logic PC_SRC_ALU    = 1'b0;
  localparam logic PC_SRC_ALUOUT = 1'b1;

  localparam logic TYPE_I = 1'b0;
  localparam logic TYPE_R = 1'b1;

endpackage

// File: rtl/mc_controller_alu_dec.sv
// rtl/mc_controller_alu_dec.sv - funct field to ALU operation mapping for the EXEC state
module alu_dec
  import mc_pkg::*;
(
  input  logic       insn_type,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  output logic [3:0] alu_ctrl
);

  always_comb begin
    alu_ctrl = ALU_ADD;
    case (funct3)
      3'b000: alu_ctrl = (insn_type == TYPE_R && funct7_5) ? ALU_SUB : ALU_ADD;
      3'b111: alu_ctrl = ALU_AND;
      3'b110: alu_ctrl = ALU_OR;
      3'b001: alu_ctrl = ALU_SLL;
      3'b101: alu_ctrl = ALU_SRL;
      3'b010: alu_ctrl = ALU_SLT;
      default: alu_ctrl = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// rtl/mc_controller.sv - multi-cycle RISC-V main control FSM
// MC_CTRL_ILLEGAL_TRAP_EN: unsupported opcodes halt and raise sticky illegal instead of retiring as NOP
module mc_controller
  import mc_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  input  logic       zero,
  output logic [3:0] alu_ctrl,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       pc_src,
  output logic       pc_write,
  output logic       ir_write,
  output logic       mem_read,
  output logic       mem_write,
  output logic       reg_write,
  output logic       i_or_d,
  output logic [1:0] mem_to_reg,
  output logic       retire,
  output logic       illegal,
  output logic [3:0] state
);

  state_t     state_q;
  state_t     state_n;
  logic       illegal_q;
  logic       insn_type;
  logic [3:0] exec_ctrl;

  assign insn_type = (opcode == OP_R) ? TYPE_R : TYPE_I;

  alu_dec u_alu_dec (
    .insn_type (insn_type),
    .funct3    (funct3),
    .funct7_5  (funct7_5),
    .alu_ctrl  (exec_ctrl)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_n;
  end

`ifdef MC_CTRL_ILLEGAL_TRAP_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    illegal_q <= 1'b0;
    else if (state_n == S_HALT) illegal_q <= 1'b1;
  end
`else
  assign illegal_q = 1'b0;
`endif

  always_comb begin
    state_n    = state_q;
    alu_ctrl   = ALU_ADD;
    alu_src_a  = SRC_A_PC;
    alu_src_b  = SRC_B_REG;
    pc_src     = PC_SRC_ALU;
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    i_or_d     = 1'b0;
    mem_to_reg = M2R_ALUOUT;
    retire     = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        ir_write  = 1'b1;
        alu_src_b = SRC_B_FOUR;
        pc_write  = 1'b1;
        state_n   = S_DECODE;
      end
      S_DECODE: begin
        // PC already holds pc+4, so the ALU folds the -4 into the branch target
        alu_src_b = SRC_B_IMM;
        alu_ctrl  = ALU_BRT;
        case (opcode)
          OP_LD, OP_SD: state_n = S_MEM_ADDR;
          OP_R, OP_I:   state_n = S_EXEC;
          OP_BR:        state_n = S_BRANCH;
          OP_JAL:       state_n = S_JAL;
          default: begin
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
            state_n = S_HALT;
`else
            retire  = 1'b1;
            state_n = S_FETCH;
`endif
          end
        endcase
      end
      S_MEM_ADDR: begin
        alu_src_a = SRC_A_REG;
        alu_src_b = SRC_B_IMM;
        state_n   = (opcode == OP_LD) ? S_MEM_READ : S_MEM_WRITE;
      end
      S_MEM_READ: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
        state_n  = S_MEM_WB;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = M2R_MDR;
        retire     = 1'b1;
        state_n    = S_FETCH;
      end
      S_MEM_WRITE: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
        retire    = 1'b1;
        state_n   = S_FETCH;
      end
      S_EXEC: begin
        alu_src_a = SRC_A_REG;
        alu_src_b = (opcode == OP_R) ? SRC_B_REG : SRC_B_IMM;
        alu_ctrl  = exec_ctrl;
        state_n   = S_ALU_WB;
      end
      S_ALU_WB: begin
        reg_write = 1'b1;
        retire    = 1'b1;
        state_n   = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a = SRC_A_REG;
        alu_ctrl  = ALU_SUB;
        pc_src    = PC_SRC_ALUOUT;
        pc_write  = (funct3 == 3'b000) ? zero : (funct3 == 3'b001) ? !zero : 1'b0;
        retire    = 1'b1;
        state_n   = S_FETCH;
      end
      S_JAL: begin
        reg_write  = 1'b1;
        mem_to_reg = M2R_PC;
        pc_write   = 1'b1;
        pc_src     = PC_SRC_ALUOUT;
        retire     = 1'b1;
        state_n    = S_FETCH;
      end
      S_HALT:  state_n = S_HALT;
      default: state_n = S_FETCH;
    endcase
    // Reset must squash every enable immediately, even though the state register already reads FETCH
    if (rst) begin
      alu_ctrl   = 4'b0000;
      alu_src_a  = 1'b0;
      alu_src_b  = 2'b00;
      pc_src     = 1'b0;
      pc_write   = 1'b0;
      ir_write   = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      reg_write  = 1'b0;
      i_or_d     = 1'b0;
      mem_to_reg = 2'b00;
      retire     = 1'b0;
    end
  end

  assign illegal = rst ? 1'b0 : illegal_q;
  assign state   = rst ? 4'd0 : state_q;

endmodule

// File: doc/mc_controller.md
# mc_controller

Multi-cycle main control FSM for the 64-bit RISC-V datapath, directly upstream of the datapath ALU. It steps each instruction through fetch, decode, execute, memory and writeback states. Per state it drives the 4-bit ALU operation code, the operand and result mux selects, and the memory, IR, PC and register-file enables. It consumes the ALU `zero` flag to resolve branches.

## Interface
- No parameters.
- `clk`  in  1  rising-edge clock
- `rst`  in  1  asynchronous, active-high reset
- `opcode`  in  7  IR[6:0]
- `funct3`  in  3  IR[14:12]
- `funct7_5`  in  1  IR[30]
- `zero`  in  1  ALU zero flag, same cycle
- `alu_ctrl`  out  4  0000 and, 0001 or, 0010 add, 0011 sll, 0100 srl, 0110 sub, 0111 slt, 1000 a+2b-4 (branch target), 1001 b+2a
- `alu_src_a`  out  1  0 PC, 1 A register
- `alu_src_b`  out  2  00 B register, 01 constant 4, 10 immediate
- `pc_src`  out  1  0 live ALU result, 1 ALUOut register
- `pc_write`, `ir_write`, `mem_read`, `mem_write`, `reg_write`  out  1 each  enables
- `i_or_d`  out  1  memory address: 0 PC, 1 ALUOut
- `mem_to_reg`  out  2  writeback source: 00 ALUOut, 01 MDR, 10 PC
- `retire`  out  1  one-cycle pulse in an instruction's last state
- `illegal`  out  1  sticky unsupported-opcode flag
- `state`  out  4  current state, for debug

## Operation
- Opcodes:
  - R `0110011`
  - I-ALU `0010011`
  - LD `0000011`
  - SD `0100011`
  - BR `1100011`
  - JAL `1101111`
- States and actions:
  - FETCH (0): `mem_read`, `ir_write`, a=PC, b=4, add, `pc_write`, `pc_src`=0.
  - DECODE (1): a=PC, b=imm, `alu_ctrl`=1000 (the PC was already advanced by 4), result latched into ALUOut. Next state by opcode: LD/SD→MEM_ADDR, R/I→EXEC, BR→BRANCH, JAL→JAL, other→see Configuration.
  - MEM_ADDR (2): a=A, b=imm, add. Next MEM_READ for LD, MEM_WRITE for SD.
  - MEM_READ (3): `mem_read`, `i_or_d`=1. Next MEM_WB.
  - MEM_WB (4): `reg_write`, `mem_to_reg`=01, `retire`. Next FETCH.
  - MEM_WRITE (5): `mem_write`, `i_or_d`=1, `retire`. Next FETCH.
  - EXEC (6): a=A, b=B for R or b=imm for I, `alu_ctrl` from funct decode. Next ALU_WB.
  - ALU_WB (7): `reg_write`, `mem_to_reg`=00, `retire`. Next FETCH.
  - BRANCH (8): a=A, b=B, sub. `pc_src`=1. `pc_write` = `zero` for funct3 000, `!zero` for 001, 0 otherwise. `retire`. Next FETCH.
  - JAL (9): `reg_write`, `mem_to_reg`=10, `pc_write`, `pc_src`=1, `retire`. Next FETCH.
  - HALT (10): all enables 0. Held until reset.
- Funct decode (EXEC):
  - 000: add, or sub when R and `funct7_5`=1. I-type ignores `funct7_5`.
  - 111 and, 110 or, 001 sll, 101 srl, 010 slt.
  - Other funct3: add.
- Any output not listed for a state is 0. In every state `alu_ctrl` defaults to 0010 unless specified.

## Timing
- State register is asynchronous-reset to FETCH.
- Outputs are combinational from state. Exception: `pc_write` in BRANCH is Mealy on `zero`.
- While `rst`=1, every output is forced to 0, `state` reads 0, and `illegal`=0.
- The first rising edge after `rst` falls completes FETCH.
- Latency in cycles, FETCH through `retire`: R/I 4, LD 5, SD 4, BR 3, JAL 3.
- `retire` is never asserted in two consecutive cycles.
- Reset asserted mid-instruction aborts it immediately. No enable remains high after reset asserts.

## Configuration
- `MC_CTRL_ILLEGAL_TRAP_EN` defined:
  - An unsupported opcode in DECODE transitions to HALT.
  - `illegal` rises on entry to HALT and stays 1 until reset.
- Macro undefined:
  - An unsupported opcode in DECODE returns to FETCH with `retire` pulsed as a NOP.
  - HALT is unreachable and `illegal` is tied 0.

## Structure
- Package `mc_pkg` holds:
  - state enum (4-bit)
  - opcode constants
  - `alu_ctrl` codes
  - `alu_src_b`, `mem_to_reg`, `pc_src` select constants
- Sub-module `alu_dec`: combinational mapping of {type, funct3, funct7_5} → `alu_ctrl`, instantiated once.

## Test plan
- Reset: hold `rst` for 3 cycles → all outputs 0. After release, cycle 1 shows `mem_read`=`ir_write`=`pc_write`=1, `alu_ctrl`=0010, `alu_src_b`=01.
- R sub (opcode 0110011, funct3 000, `funct7_5`=1) → states 0,1,6,7. EXEC `alu_ctrl`=0110. `reg_write`, `retire` in cycle 4.
- LD → states 0,1,2,3,4. `i_or_d`=1 in state 3. `mem_to_reg`=01 with `reg_write` in state 4.
- BEQ with `zero`=1 → `pc_write`=1, `pc_src`=1 in state 8. BNE with `zero`=1 → `pc_write`=0.
- JAL → DECODE `alu_ctrl`=1000. State 9 shows `reg_write`, `mem_to_reg`=10, `pc_write`.
- Opcode 1111111 → with `MC_CTRL_ILLEGAL_TRAP_EN`: HALT with `illegal`=1 held for 10 cycles, cleared by `rst`. Without the macro: back to FETCH after 2 cycles.
